// File: rtl/demux_1_to_2_stream.sv
// Registered 1-to-2 stream demultiplexer: each word is steered by in_sel into one
// of two independent 2-entry output FIFOs, each with its own accepted-word counter.

module demux_1_to_2_fifo2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  cnt
);

  // state | meaning
  // EMPTY | no word buffered, valid low
  // ONE   | head holds the only word
  // FULL  | head holds the oldest word, tail the newer one; push blocked
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = push ? cnt_q + CNT_ONE : cnt_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = push_data;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          // Simultaneous push/pop: the new word replaces the departing head.
          2'b11: head_d = push_data;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid = (state_q != EMPTY);
  assign full  = (state_q == FULL);
  assign data  = head_q;
  assign cnt   = cnt_q;

endmodule

module demux_1_to_2_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;

  // Ready depends only on the selected FIFO so a stalled output never blocks the other.
  assign in_ready = in_sel ? !full1 : !full0;

  assign push0 = in_valid && in_ready && !in_sel;
  assign push1 = in_valid && in_ready &&  in_sel;
  assign pop0  = out0_valid && out0_ready;
  assign pop1  = out1_valid && out1_ready;

  demux_1_to_2_fifo2 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .pop       (pop0),
    .push_data (in_data),
    .valid     (out0_valid),
    .full      (full0),
    .data      (out0_data),
    .cnt       (cnt0)
  );

  demux_1_to_2_fifo2 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .pop       (pop1),
    .push_data (in_data),
    .valid     (out1_valid),
    .full      (full1),
    .data      (out1_data),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux_1_to_2_stream.sv
// Directed bench for demux_1_to_2_stream: a default-width instance and a 4-bit
// counter instance share the same stimulus; expected values are hand-computed.

module tb_demux_1_to_2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sel;
  logic       out0_ready;
  logic       out1_ready;

  logic       in_ready, out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data, cnt0, cnt1;

  logic       w_in_ready, w_out0_valid, w_out1_valid;
  logic [7:0] w_out0_data, w_out1_data;
  logic [3:0] w_cnt0, w_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1_to_2_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  demux_1_to_2_stream #(.DATA_W(8), .CNT_W(4)) dut_w4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (w_in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (w_out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (w_out0_data),
    .out1_valid (w_out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (w_out1_data),
    .cnt0       (w_cnt0),
    .cnt1       (w_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // v   sel   data    r0    r1  | rdy | post-edge: v0 d0  v1  d1  c0 c1
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'd1, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 8'd1, 8'd1};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd1, 8'd1};
    vecs[3] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 8'd2, 8'd1};
    vecs[4] = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 8'd3, 8'd1};
    vecs[5] = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 8'd3, 8'd1};
    vecs[6] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 8'h10, 8'd3, 8'd2};
    vecs[7] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 8'd3, 8'd2};
    vecs[8] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 8'd4, 8'd2};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd4, 8'd2};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;

    // Reset with random inputs on the bus.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", 32'(out0_data), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    in_sel = 1'b0;
    #1;
    chk("rst_in_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    chk("rst_in_ready_sel1", 32'(in_ready), 32'd1);

    // Steering, back-pressure, isolation and in-order drain.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(vecs[i].e_v0));
      if (vecs[i].e_v0) chk($sformatf("vec%0d_out0_data", i), 32'(out0_data), 32'(vecs[i].e_d0));
      chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].e_v1));
      if (vecs[i].e_v1) chk($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].e_d1));
      chk($sformatf("vec%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].e_c0));
      chk($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].e_c1));
      chk($sformatf("vec%0d_w4_cnt0", i), 32'(w_cnt0), 32'(vecs[i].e_c0[3:0]));
    end

    // Sustained push/pop to out1: one word per cycle, in order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'(8'h40 + i), 1'b1, 1'b1);
      #1;
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("stream%0d_out1_valid", i), 32'(out1_valid), 32'd1);
        chk($sformatf("stream%0d_out1_data", i), 32'(out1_data), 32'(8'h40 + i - 1));
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    chk("stream_last_valid", 32'(out1_valid), 32'd1);
    chk("stream_last_data", 32'(out1_data), 32'h53);
    chk("stream_cnt1", 32'(cnt1), 32'd20);
    chk("stream_w4_cnt1", 32'(w_cnt1), 32'd4);
    chk("stream_out0_idle", 32'(out0_valid), 32'd0);
    tick();
    chk("stream_drained", 32'(out1_valid), 32'd0);

    // Counter wrap on the 4-bit instance, then reset with two words buffered.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
      tick();
    end
    chk("wrap_cnt0", 32'(cnt0), 32'd17);
    chk("wrap_w4_cnt0", 32'(w_cnt0), 32'd1);
    drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'hEF, 1'b0, 1'b1);
    #1;
    chk("wrap_full_in_ready", 32'(w_in_ready), 32'd0);
    chk("wrap_full_head", 32'(w_out0_data), 32'h10);
    chk("wrap_full_w4_cnt0", 32'(w_cnt0), 32'd2);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'hEF, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    chk("midrst_out0_valid", 32'(out0_valid), 32'd0);
    chk("midrst_w4_out0_valid", 32'(w_out0_valid), 32'd0);
    chk("midrst_out0_data", 32'(w_out0_data), 32'd0);
    chk("midrst_cnt0", 32'(cnt0), 32'd0);
    chk("midrst_w4_cnt0", 32'(w_cnt0), 32'd0);
    chk("midrst_in_ready", 32'(w_in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
